// File: rtl/noror_sweep_ctrl_pkg.sv
// Shared types and constants for the OR/NOR gate self-test sequencer.
package noror_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        CHECK  = 2'd2,
        DONE   = 2'd3
    } state_e;

    localparam int NUM_VEC = 16;
    localparam int VEC_W   = 4;
    localparam int ERR_W   = 5;

    function automatic logic exp_or(input logic [VEC_W-1:0] vec);
        return |vec;
    endfunction

endpackage

// File: rtl/noror_sweep_ctrl_if.sv
// Signal bundle between the sweep controller and the gate under test / host.
import noror_pkg::*;

interface noror_sweep_ctrl_if;
    logic             start;
    logic             x;
    logic             y;
    logic             a;
    logic             b;
    logic             c;
    logic             d;
    logic             busy;
    logic             done;
    logic             pass;
    logic [ERR_W-1:0] err_cnt;
    logic [VEC_W-1:0] first_fail;
    logic             fail_seen;

    modport master (
        input  start, x, y,
        output a, b, c, d, busy, done, pass, err_cnt, first_fail, fail_seen
    );

    modport slave (
        output start, x, y,
        input  a, b, c, d, busy, done, pass, err_cnt, first_fail, fail_seen
    );
endinterface

// File: rtl/noror_sweep_ctrl.sv
// Drives all 16 vectors into a 4-input OR/NOR block, samples x/y after a
// settle delay and accumulates error count, pass flag and first failing vector.
module noror_sweep_ctrl
    import noror_pkg::*;
#(
    parameter int SETTLE_CYCLES = 2
) (
    input  logic                clk,
    input  logic                rst,
    noror_sweep_ctrl_if.master  bus
);

    localparam logic [3:0] RELOAD = 4'(SETTLE_CYCLES - 1);

    state_e           state_q, state_d;
    logic [VEC_W-1:0] vec_q, vec_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [ERR_W-1:0] err_q, err_d;
    logic [VEC_W-1:0] ff_q, ff_d;
    logic             fs_q, fs_d;
    logic             pass_q, pass_d;
    logic [VEC_W-1:0] abcd_q, abcd_d;
    logic             mismatch;

    // Both outputs wrong still counts as a single failing vector.
    assign mismatch = (bus.x != exp_or(vec_q)) || (bus.y != ~exp_or(vec_q));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            vec_q   <= '0;
            cnt_q   <= '0;
            err_q   <= '0;
            ff_q    <= '0;
            fs_q    <= 1'b0;
            pass_q  <= 1'b0;
            abcd_q  <= '0;
        end else begin
            state_q <= state_d;
            vec_q   <= vec_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            ff_q    <= ff_d;
            fs_q    <= fs_d;
            pass_q  <= pass_d;
            abcd_q  <= abcd_d;
        end
    end

    always_comb begin
        state_d = state_q;
        vec_d   = vec_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        ff_d    = ff_q;
        fs_d    = fs_q;
        pass_d  = pass_q;
        abcd_d  = abcd_q;
        case (state_q)
            IDLE: begin
                abcd_d = '0;
                if (bus.start) begin
                    state_d = SETTLE;
                    vec_d   = '0;
                    cnt_d   = RELOAD;
                    err_d   = '0;
                    ff_d    = '0;
                    fs_d    = 1'b0;
                    pass_d  = 1'b0;
                end
            end
            SETTLE: begin
                if (cnt_q == '0) state_d = CHECK;
                else             cnt_d   = cnt_q - 4'd1;
            end
            CHECK: begin
                if (mismatch) begin
                    err_d = err_q + 1'b1;
                    if (!fs_q) begin
                        ff_d = vec_q;
                        fs_d = 1'b1;
                    end
                end
                // pass must already be valid in the DONE cycle, so use the updated count.
                if (vec_q == VEC_W'(NUM_VEC - 1)) begin
                    state_d = DONE;
                    pass_d  = (err_d == '0);
                end else begin
                    state_d = SETTLE;
                    vec_d   = vec_q + 1'b1;
                    abcd_d  = vec_q + 1'b1;
                    cnt_d   = RELOAD;
                end
            end
            DONE: begin
                state_d = IDLE;
                abcd_d  = '0;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.busy = (state_q != IDLE);
        bus.done = (state_q == DONE);
    end

    assign {bus.a, bus.b, bus.c, bus.d} = abcd_q;
    assign bus.err_cnt    = err_q;
    assign bus.first_fail = ff_q;
    assign bus.fail_seen  = fs_q;
    assign bus.pass       = pass_q;

endmodule

// File: tb/tb_noror_sweep_ctrl.sv
// Bench for noror_sweep_ctrl: gate model with per-vector fault masks, checked
// against a vector-counting reference of the expected sweep results.
module tb_noror_sweep_ctrl;

    localparam int S       = 2;
    localparam int LAT     = 16 * (S + 1) + 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [15:0] fx = '0;
    logic [15:0] fy = '0;
    int n_chk  = 0;
    int n_fail = 0;

    noror_sweep_ctrl_if bus ();

    noror_sweep_ctrl #(.SETTLE_CYCLES(S)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Gate under test: correct OR/NOR, with a fault bit inverting an output for a given vector.
    always_comb begin
        logic [3:0] v;
        v     = {bus.a, bus.b, bus.c, bus.d};
        bus.x = (|v) ^ fx[v];
        bus.y = (~(|v)) ^ fy[v];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model(input logic [15:0] mx, input logic [15:0] my,
                         output int e, output int first, output bit seen);
        e = 0; first = 0; seen = 0;
        for (int v = 0; v < 16; v++) begin
            if (mx[v] || my[v]) begin
                if (!seen) begin first = v; seen = 1; end
                e++;
            end
        end
    endtask

    task automatic sweep(input logic [15:0] mx, input logic [15:0] my, input bit repulse);
        int e, first;
        bit seen;
        model(mx, my, e, first, seen);
        fx = mx; fy = my;
        @(negedge clk) bus.start = 1'b1;
        for (int n = 1; n <= LAT + 1; n++) begin
            @(posedge clk); #1;
            bus.start = (repulse && n == 4) ? 1'b1 : 1'b0;
            if (n < LAT) begin
                chk("vec", {bus.a, bus.b, bus.c, bus.d}, (n - 1) / (S + 1));
                chk("busy", bus.busy, 1);
                chk("done_lo", bus.done, 0);
            end else if (n == LAT) begin
                chk("done", bus.done, 1);
                chk("busy_done", bus.busy, 1);
                chk("err_cnt", bus.err_cnt, e);
                chk("pass", bus.pass, (e == 0));
                chk("first_fail", bus.first_fail, first);
                chk("fail_seen", bus.fail_seen, seen);
            end else begin
                chk("done_after", bus.done, 0);
                chk("busy_after", bus.busy, 0);
                chk("abcd_idle", {bus.a, bus.b, bus.c, bus.d}, 0);
            end
        end
        repeat (3) @(posedge clk);
        #1;
        chk("err_hold", bus.err_cnt, e);
        chk("pass_hold", bus.pass, (e == 0));
        chk("ff_hold", bus.first_fail, first);
    endtask

    initial begin
        logic [15:0] rx, ry;
        bus.start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_pass", bus.pass, 0);
        chk("rst_err", bus.err_cnt, 0);
        chk("rst_ff", bus.first_fail, 0);
        chk("rst_fs", bus.fail_seen, 0);
        chk("rst_abcd", {bus.a, bus.b, bus.c, bus.d}, 0);
        @(negedge clk) rst = 1'b0;

        sweep(16'h0000, 16'h0000, 1'b0);
        sweep(16'hFFFE, 16'h0000, 1'b0);
        sweep(16'hFFFF, 16'hFFFF, 1'b0);
        sweep(16'h0000, 16'h0400, 1'b0);
        sweep(16'h0000, 16'h0000, 1'b1);

        // Reset while vector 7 is being driven.
        fx = 16'hFFFF; fy = 16'h0000;
        @(negedge clk) bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        for (int n = 2; n <= 7 * (S + 1) + 1; n++) begin
            @(posedge clk); #1;
        end
        chk("mid_vec", {bus.a, bus.b, bus.c, bus.d}, 7);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("mrst_busy", bus.busy, 0);
        chk("mrst_abcd", {bus.a, bus.b, bus.c, bus.d}, 0);
        chk("mrst_err", bus.err_cnt, 0);
        chk("mrst_fs", bus.fail_seen, 0);
        sweep(16'h0000, 16'h0000, 1'b0);

        for (int i = 0; i < 6; i++) begin
            rx = 16'($urandom) & 16'($urandom) & 16'($urandom);
            ry = 16'($urandom) & 16'($urandom);
            sweep(rx, ry, ($urandom_range(0, 1) == 1));
        end

        $display("[TB] %0d tests run, %0d failed", n_chk, n_fail);
        $finish;
    end

endmodule
